// File: rtl/mem_issue_buffer.sv
// Purpose: in-order issue buffer that sits between the load/store queue and data memory; DEPTH-entry FIFO plus one output register.
// Latency: 2 cycles from acceptance to valid_out_M, or 1 cycle when MEM_ISSUE_BYPASS_EN is defined and the buffer is empty.
// Backpressure: stall_in_M freezes the output register; stall_out = registered full; requests arriving while full are dropped and drop_err is set.
module mem_issue_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_in,
    input  logic                     rw_in,
    input  logic [31:0]              addr_in,
    input  logic [31:0]              data_in,
    input  logic [3:0]               id_in,
    output logic                     stall_out,
    output logic                     valid_out_M,
    output logic                     rw_out_M,
    output logic [31:0]              addr_out_M,
    output logic [31:0]              data_out_M,
    output logic [3:0]               ldstID_out_M,
    input  logic                     stall_in_M,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("mem_issue_buffer: DEPTH must be a power of two and at least 2");
    end

    typedef struct packed {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  id;
    } req_t;

    req_t            mem_q [DEPTH];
    req_t            mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            vld_q, vld_d;
    req_t            out_q, out_d;
    logic            drop_err_q, drop_err_d;

    req_t            in_req;
    logic            xfer, out_free, fifo_empty, fifo_full;
    logic            push, byp, fifo_wr, pop;

    always_comb begin
        in_req     = '{rw: rw_in, addr: addr_in, data: data_in, id: id_in};
        xfer       = vld_q & ~stall_in_M;
        out_free   = ~vld_q | xfer;
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == FULL_CNT);
        // Acceptance looks only at registered occupancy, so a same-edge pop never frees a slot for a full-time arrival.
        push       = valid_in & ~fifo_full;
`ifdef MEM_ISSUE_BYPASS_EN
        byp        = push & out_free & fifo_empty;
`else
        byp        = 1'b0;
`endif
        fifo_wr    = push & ~byp;
        pop        = out_free & ~fifo_empty;

        mem_d = mem_q;
        if (fifo_wr) begin
            mem_d[wr_ptr_q] = in_req;
        end

        wr_ptr_d = wr_ptr_q;
        if (fifo_wr) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end

        rd_ptr_d = rd_ptr_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        count_d = count_q;
        case ({fifo_wr, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Fields hold their last value when the register empties; only the valid bit drops.
        out_d = out_q;
        vld_d = vld_q;
        if (pop) begin
            out_d = mem_q[rd_ptr_q];
            vld_d = 1'b1;
        end else if (byp) begin
            out_d = in_req;
            vld_d = 1'b1;
        end else if (out_free) begin
            vld_d = 1'b0;
        end

        drop_err_d = drop_err_q | (valid_in & fifo_full);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            vld_q      <= 1'b0;
            out_q      <= '0;
            drop_err_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            vld_q      <= vld_d;
            out_q      <= out_d;
            drop_err_q <= drop_err_d;
        end
    end

    // Storage is not reset; the pointers and count alone decide which entries are live.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign stall_out    = (count_q == FULL_CNT);
    assign count        = count_q;
    assign drop_err     = drop_err_q;
    assign valid_out_M  = vld_q;
    assign rw_out_M     = out_q.rw;
    assign addr_out_M   = out_q.addr;
    assign data_out_M   = out_q.data;
    assign ldstID_out_M = out_q.id;

endmodule

// File: tb/tb_mem_issue_buffer.sv
// Bench for mem_issue_buffer: scoreboard of expected issues checked at the falling edge whenever a transfer is about to occur.
module tb_mem_issue_buffer;

    localparam int DEPTH = 4;
`ifdef MEM_ISSUE_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, rw_in, stall_in_M;
    logic [31:0] addr_in, data_in;
    logic [3:0]  id_in;
    logic        stall_out, valid_out_M, rw_out_M, drop_err;
    logic [31:0] addr_out_M, data_out_M;
    logic [3:0]  ldstID_out_M;
    logic [$clog2(DEPTH):0] count;

    typedef logic [68:0] req_t;
    req_t exp_q[$];
    req_t mon_e;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    mem_issue_buffer #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_in     (valid_in),
        .rw_in        (rw_in),
        .addr_in      (addr_in),
        .data_in      (data_in),
        .id_in        (id_in),
        .stall_out    (stall_out),
        .valid_out_M  (valid_out_M),
        .rw_out_M     (rw_out_M),
        .addr_out_M   (addr_out_M),
        .data_out_M   (data_out_M),
        .ldstID_out_M (ldstID_out_M),
        .stall_in_M   (stall_in_M),
        .count        (count),
        .drop_err     (drop_err)
    );

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Drives one request for one cycle; returns 1 time unit after the accepting edge.
    task automatic send(input logic rw, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] id, input bit dropped);
        valid_in = 1'b1;
        rw_in    = rw;
        addr_in  = a;
        data_in  = d;
        id_in    = id;
        if (!dropped) exp_q.push_back({rw, a, d, id});
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_vld"},   valid_out_M,  0);
        chk({tag, "_rw"},    rw_out_M,     0);
        chk({tag, "_addr"},  addr_out_M,   0);
        chk({tag, "_data"},  data_out_M,   0);
        chk({tag, "_id"},    ldstID_out_M, 0);
        chk({tag, "_count"}, count,        0);
        chk({tag, "_stall"}, stall_out,    0);
        chk({tag, "_drop"},  drop_err,     0);
    endtask

    always @(negedge clk) begin
        if (rst && valid_out_M && !stall_in_M) begin
            if (exp_q.size() == 0) begin
                chk("spurious_issue", {rw_out_M, addr_out_M, data_out_M, ldstID_out_M}, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("issue", {rw_out_M, addr_out_M, data_out_M, ldstID_out_M}, mon_e);
            end
        end
    end

    initial begin
        rst        = 1'b0;
        valid_in   = 1'b0;
        rw_in      = 1'b0;
        addr_in    = '0;
        data_in    = '0;
        id_in      = '0;
        stall_in_M = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_cleared("reset");
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single load: valid_out_M high for exactly one cycle, LAT edges after acceptance.
        send(1'b0, 32'h10, 32'h0, 4'd3, 0);
        for (int k = 1; k <= 3; k++) begin
            chk($sformatf("load_vld_e%0d", k), valid_out_M, (k == LAT));
            if (k == LAT) begin
                chk("load_addr", addr_out_M, 32'h10);
                chk("load_id",   ldstID_out_M, 4'd3);
                chk("load_rw",   rw_out_M, 1'b0);
            end
            if (k < 3) begin
                @(posedge clk);
                #1;
            end
        end

        // Backpressure fill, drop while full, then release.
        stall_in_M = 1'b1;
        for (int i = 0; i < 5; i++) send(1'b1, 32'h100 + i, 32'hD0 + i, 4'(i), 0);
        chk("bp_count", count, 4);
        chk("bp_stall", stall_out, 1);
        chk("bp_vld",   valid_out_M, 1);
        chk("bp_head",  ldstID_out_M, 0);
        send(1'b1, 32'h105, 32'hD5, 4'd5, 1);
        chk("drop_err",   drop_err, 1);
        chk("drop_count", count, 4);
        chk("hold_id",    ldstID_out_M, 0);
        chk("hold_addr",  addr_out_M, 32'h100);
        stall_in_M = 1'b0;
        @(posedge clk);
        #1;
        chk("release_stall", stall_out, 0);
        chk("release_count", count, 3);
        repeat (4) @(posedge clk);
        #1;
        chk("burst_left",  exp_q.size(), 0);
        chk("burst_idle",  valid_out_M, 0);
        chk("drop_sticky", drop_err, 1);

        // Reset in the middle of traffic discards everything.
        stall_in_M = 1'b1;
        for (int i = 8; i < 11; i++) send(1'b0, 32'h300 + i, 32'h0, 4'(i), 0);
        #3;
        rst = 1'b0;
        #1;
        chk_cleared("midreset");
        exp_q.delete();
        stall_in_M = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("post_reset_vld",   valid_out_M, 0);
        chk("post_reset_count", count, 0);

        // Steady stream with two entries buffered, running past several pointer wraps.
        stall_in_M = 1'b1;
        for (int n = 0; n < 3; n++) send(1'b1, 32'h2000 + 4 * n, 32'hA5A5_0000 + n, 4'(n), 0);
        chk("stream_prefill", count, 2);
        stall_in_M = 1'b0;
        for (int n = 3; n < 3 + 3 * DEPTH + 4; n++) begin
            send(1'b1, 32'h2000 + 4 * n, 32'hA5A5_0000 + n, 4'(n), 0);
            chk($sformatf("stream_count_%0d", n), count, 2);
        end
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("stream_drain", exp_q.size(), 0);
        chk("stream_empty", count, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_issue_buffer.md
MEM_ISSUE_BUFFER -- requirements
Module: mem_issue_buffer

Interface
REQ-001 The block SHALL have one parameter: DEPTH, default 4, FIFO entry count, power of two, minimum 2.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  reset, asynchronous, active-low: one clock; reset is asynchronous and active-low.
REQ-004 valid_in  in  1  request from the load/store queue is present this cycle.
REQ-005 rw_in  in  1  1 = store, 0 = load.
REQ-006 addr_in  in  32  request address.
REQ-007 data_in  in  32  store data; ignored for loads but carried through.
REQ-008 id_in  in  4  load/store queue id.
REQ-009 stall_out  out  1  buffer full; the load/store queue SHALL NOT present requests.
REQ-010 valid_out_M  out  1  request presented to data memory.
REQ-011 rw_out_M  out  1; addr_out_M  out  32; data_out_M  out  32; ldstID_out_M  out  4  -- the presented request.
REQ-012 stall_in_M  in  1  memory cannot accept this cycle.
REQ-013 count  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH, excluding the output register.
REQ-014 drop_err  out  1  sticky: a request arrived while full and was lost.

Function
REQ-015 Storage SHALL be a DEPTH-entry circular FIFO of {rw, addr, data, id} plus one output register driving all *_M outputs.
REQ-016 Push SHALL occur at a rising edge when valid_in=1 and count<DEPTH.
REQ-017 Transfer to memory SHALL occur at a rising edge when valid_out_M=1 and stall_in_M=0.
REQ-018 The output register is free when valid_out_M=0 or a transfer occurs at that edge.
REQ-019 When the output register is free and count>0, it SHALL load the FIFO head at that edge (pop); valid_out_M=1 afterwards.
REQ-020 When the output register is free, count=0 and no request is pushed, valid_out_M SHALL go 0; the other *_M outputs hold their last values.
REQ-021 Requests SHALL reach memory in arrival order; fields SHALL pass unmodified.
REQ-022 stall_out SHALL equal (count==DEPTH), derived from registered state only; it has no combinational path from any input.
REQ-023 valid_in=1 while count==DEPTH SHALL be refused even if a pop occurs at the same edge; drop_err SHALL set to 1 and hold until reset.
REQ-024 Simultaneous push and pop SHALL leave count unchanged; order SHALL be preserved.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH nor underflow below 0.
REQ-026 A request held by the output register under stall_in_M=1 SHALL remain stable, fields unchanged, until transferred.

Reset
REQ-027 rst=0 SHALL immediately clear count, pointers, drop_err, valid_out_M, rw_out_M, addr_out_M, data_out_M and ldstID_out_M to 0; stall_out reads 0.
REQ-028 Reset mid-operation SHALL discard all buffered and presented requests; none is issued after reset.
REQ-029 FIFO storage contents need not be cleared.

Configuration
REQ-030 Macro MEM_ISSUE_BYPASS_EN defined: when the output register is free and count=0, a pushed request SHALL load the output register directly at that edge; valid_out_M rises 1 cycle after acceptance.
REQ-031 Macro undefined: every request SHALL pass through the FIFO; it is pushed at edge N and popped at N+1, so valid_out_M rises 2 cycles after acceptance. All other behaviour is identical.

Verification
REQ-032 Reset: hold rst=0 mid-traffic -> all outputs 0 at once, count=0, no later issue of old requests.
REQ-033 Single load, addr 0x10, id 3, stall_in_M=0 -> valid_out_M=1 for exactly one cycle, addr_out_M=0x10, ldstID_out_M=3, rw_out_M=0. It rises after edge 1 with the macro defined, after edge 2 without.
REQ-034 Backpressure, MEM_ISSUE_BYPASS_EN defined, stall_in_M=1, ids 0..4 pushed on consecutive cycles -> id 0 held on *_M, count=4, stall_out=1 after 5th edge.
REQ-035 While full, push id 5 -> drop_err=1, count stays 4. Then stall_in_M=0 -> ids 0,1,2,3,4 issued on consecutive cycles, id 5 never issued, stall_out drops after the first pop.
REQ-036 count=2, stall_in_M=0, continuous push stream of stores with data 0xA5A5_0000+n -> count holds 2, each store issued with matching data, strict order across pointer wrap (>=3*DEPTH requests).
